// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = the control FSM, slave = the datapath / instruction register side.
interface multicycle_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic       instr_done;

  modport master (
    input  op, funct, mem_ready,
    output pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
           state, instr_done
  );

  modport slave (
    output op, funct, mem_ready,
    input  pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
           state, instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control unit: state register plus combinational
// decode of datapath strobes and mux selects from the current state.
module multicycle_control_fsm (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXEC     = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t state_q, state_d;
  logic   load_q;
  logic   rtype_ok;

  // Load/store choice is captured in DECODE so op may change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) load_q <= (ctrl.op == OP_LW);
    end
  end

  assign rtype_ok   = ctrl.funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  assign ctrl.state = state_q;

  always_comb begin
    state_d          = FETCH;
    ctrl.pc_write    = 1'b0;
    ctrl.branch      = 1'b0;
    ctrl.iord        = 1'b0;
    ctrl.mem_read    = 1'b0;
    ctrl.mem_write   = 1'b0;
    ctrl.ir_write    = 1'b0;
    ctrl.reg_dst     = 1'b0;
    ctrl.mem_to_reg  = 1'b0;
    ctrl.reg_write   = 1'b0;
    ctrl.alu_src_a   = 1'b0;
    ctrl.alu_src_b   = 2'b00;
    ctrl.pc_src      = 2'b00;
    ctrl.alu_control = 3'b010;
    ctrl.instr_done  = 1'b0;

    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = ctrl.mem_ready;
        ctrl.ir_write  = ctrl.mem_ready;
        state_d        = ctrl.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE: begin
            state_d         = rtype_ok ? EXEC : FETCH;
            ctrl.instr_done = !rtype_ok;
          end
          OP_BEQ:  state_d = BRANCH;
          OP_ADDI: state_d = ADDIEXEC;
          OP_J:    state_d = JUMP;
          default: ctrl.instr_done = 1'b1;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = load_q ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        state_d       = ctrl.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = ctrl.mem_ready;
        state_d         = ctrl.mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        state_d        = ALUWB;
        case (ctrl.funct)
          FN_SUB:  ctrl.alu_control = 3'b110;
          FN_AND:  ctrl.alu_control = 3'b000;
          FN_OR:   ctrl.alu_control = 3'b001;
          FN_SLT:  ctrl.alu_control = 3'b111;
          default: ctrl.alu_control = 3'b010;
        endcase
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_control = 3'b110;
        ctrl.pc_src      = 2'b01;
        ctrl.branch      = 1'b1;
        ctrl.instr_done  = 1'b1;
      end
      ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src     = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset holds FETCH mux values but suppresses every write/retire strobe.
    if (rst) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ir_write   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven check of the multicycle control FSM plus latency
// sequences with memory wait states.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
  } ctrl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mr;
    logic [3:0] st;
    ctrl_t      exp;
  } vec_t;

  localparam ctrl_t F0      = '{mem_read:1'b1, alu_src_b:2'b01, alu_control:3'b010, default:'0};
  localparam ctrl_t F1      = '{pc_write:1'b1, ir_write:1'b1, mem_read:1'b1, alu_src_b:2'b01, alu_control:3'b010, default:'0};
  localparam ctrl_t DEC     = '{alu_src_b:2'b11, alu_control:3'b010, default:'0};
  localparam ctrl_t DEC_BAD = '{alu_src_b:2'b11, alu_control:3'b010, instr_done:1'b1, default:'0};
  localparam ctrl_t MADR    = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_control:3'b010, default:'0};
  localparam ctrl_t MRD     = '{iord:1'b1, mem_read:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t MWB     = '{mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t MWR0    = '{iord:1'b1, mem_write:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t MWR1    = '{iord:1'b1, mem_write:1'b1, instr_done:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t EX_ADD  = '{alu_src_a:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t EX_SUB  = '{alu_src_a:1'b1, alu_control:3'b110, default:'0};
  localparam ctrl_t EX_AND  = '{alu_src_a:1'b1, alu_control:3'b000, default:'0};
  localparam ctrl_t EX_OR   = '{alu_src_a:1'b1, alu_control:3'b001, default:'0};
  localparam ctrl_t EX_SLT  = '{alu_src_a:1'b1, alu_control:3'b111, default:'0};
  localparam ctrl_t AWB     = '{reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t BR      = '{alu_src_a:1'b1, alu_control:3'b110, pc_src:2'b01, branch:1'b1, instr_done:1'b1, default:'0};
  localparam ctrl_t AIE     = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_control:3'b010, default:'0};
  localparam ctrl_t AIW     = '{reg_write:1'b1, instr_done:1'b1, alu_control:3'b010, default:'0};
  localparam ctrl_t JMP     = '{pc_src:2'b10, pc_write:1'b1, instr_done:1'b1, alu_control:3'b010, default:'0};

  logic  clk = 1'b0;
  logic  rst;
  ctrl_t act;
  vec_t  vecs[$];
  int    checks = 0;
  int    failures = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.master)
  );

  always #5 clk = ~clk;

  assign act = {bus.pc_write, bus.branch, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.alu_control,
                bus.instr_done};

  function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                              input logic mr, input logic [3:0] st, input ctrl_t exp);
    vec_t v;
    v.rst = r; v.op = op; v.funct = fn; v.mr = mr; v.st = st; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Entered at posedge+1 in FETCH; counts cycles up to and including the retire pulse.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_waits, input int mem_waits, input int exp_cycles);
    int fw = fetch_waits;
    int mw = mem_waits;
    int got = -1;
    bus.op = op;
    bus.funct = fn;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.mem_ready = 1'b1;
      if (bus.state == 4'd0 && fw > 0) begin
        bus.mem_ready = 1'b0; fw--;
      end else if ((bus.state == 4'd3 || bus.state == 4'd5) && mw > 0) begin
        bus.mem_ready = 1'b0; mw--;
      end
      @(negedge clk);
      if (bus.instr_done) begin
        got = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got != exp_cycles) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, got, exp_cycles);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.state != 4'd0) begin
      failures++;
      $display("FAIL %s return_to_fetch: state %0d, want 0", name, bus.state);
    end
  endtask

  initial begin
    logic [5:0] fns[4];
    ctrl_t      exs[4];
    fns = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    exs = '{EX_SUB, EX_AND, EX_OR, EX_SLT};

    rst = 1'b1;
    bus.op = '0;
    bus.funct = '0;
    bus.mem_ready = 1'b1;

    // reset: strobes masked regardless of mem_ready
    add(1, 6'h00, 6'h00, 1, 0, F0);
    add(1, 6'h00, 6'h00, 0, 0, F0);
    // ADD
    add(0, 6'h00, 6'h20, 1, 0, F1);
    add(0, 6'h00, 6'h20, 1, 1, DEC);
    add(0, 6'h00, 6'h20, 1, 6, EX_ADD);
    add(0, 6'h00, 6'h20, 1, 7, AWB);
    // SUB/AND/OR/SLT
    for (int i = 0; i < 4; i++) begin
      add(0, 6'h00, fns[i], 1, 0, F1);
      add(0, 6'h00, fns[i], 1, 1, DEC);
      add(0, 6'h00, fns[i], 1, 6, exs[i]);
      add(0, 6'h00, fns[i], 1, 7, AWB);
    end
    // LW with op changed after DECODE and two MEMRD waits
    add(0, 6'h23, 6'h00, 1, 0, F1);
    add(0, 6'h23, 6'h00, 1, 1, DEC);
    add(0, 6'h2B, 6'h00, 1, 2, MADR);
    add(0, 6'h23, 6'h00, 0, 3, MRD);
    add(0, 6'h23, 6'h00, 0, 3, MRD);
    add(0, 6'h23, 6'h00, 1, 3, MRD);
    add(0, 6'h23, 6'h00, 1, 4, MWB);
    // SW with one FETCH wait and one MEMWR wait
    add(0, 6'h2B, 6'h00, 0, 0, F0);
    add(0, 6'h2B, 6'h00, 1, 0, F1);
    add(0, 6'h2B, 6'h00, 1, 1, DEC);
    add(0, 6'h2B, 6'h00, 1, 2, MADR);
    add(0, 6'h2B, 6'h00, 0, 5, MWR0);
    add(0, 6'h2B, 6'h00, 1, 5, MWR1);
    // BEQ then J
    add(0, 6'h04, 6'h00, 1, 0, F1);
    add(0, 6'h04, 6'h00, 1, 1, DEC);
    add(0, 6'h04, 6'h00, 1, 8, BR);
    add(0, 6'h02, 6'h00, 1, 0, F1);
    add(0, 6'h02, 6'h00, 1, 1, DEC);
    add(0, 6'h02, 6'h00, 1, 11, JMP);
    // ADDI
    add(0, 6'h08, 6'h00, 1, 0, F1);
    add(0, 6'h08, 6'h00, 1, 1, DEC);
    add(0, 6'h08, 6'h00, 1, 9, AIE);
    add(0, 6'h08, 6'h00, 1, 10, AIW);
    // illegal op, unsupported R-type funct
    add(0, 6'h3F, 6'h00, 1, 0, F1);
    add(0, 6'h3F, 6'h00, 1, 1, DEC_BAD);
    add(0, 6'h00, 6'h00, 1, 0, F1);
    add(0, 6'h00, 6'h00, 1, 1, DEC_BAD);
    // reset asserted mid-MEMWR, then a normal ADD
    add(0, 6'h2B, 6'h00, 1, 0, F1);
    add(0, 6'h2B, 6'h00, 1, 1, DEC);
    add(0, 6'h2B, 6'h00, 1, 2, MADR);
    add(0, 6'h2B, 6'h00, 0, 5, MWR0);
    add(1, 6'h2B, 6'h00, 1, 0, F0);
    add(1, 6'h2B, 6'h00, 1, 0, F0);
    add(0, 6'h00, 6'h20, 1, 0, F1);
    add(0, 6'h00, 6'h20, 1, 1, DEC);
    add(0, 6'h00, 6'h20, 1, 6, EX_ADD);
    add(0, 6'h00, 6'h20, 1, 7, AWB);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      bus.op = vecs[i].op;
      bus.funct = vecs[i].funct;
      bus.mem_ready = vecs[i].mr;
      @(negedge clk);
      checks++;
      if (bus.state != vecs[i].st) begin
        failures++;
        $display("FAIL vec%0d state: got %0d want %0d", i, bus.state, vecs[i].st);
      end
      checks++;
      if (act != vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d ctrl: got %h want %h", i, act, vecs[i].exp);
      end
    end

    @(posedge clk); #1;
    run_instr("lw_waits",   6'h23, 6'h00, 2, 3, 10);
    run_instr("sw_waits",   6'h2B, 6'h00, 1, 2, 7);
    run_instr("beq",        6'h04, 6'h00, 0, 0, 3);
    run_instr("j",          6'h02, 6'h00, 0, 0, 3);
    run_instr("addi",       6'h08, 6'h00, 0, 0, 4);
    run_instr("add",        6'h00, 6'h20, 0, 0, 4);
    run_instr("slt_fwait",  6'h00, 6'h2A, 3, 0, 7);
    run_instr("illegal",    6'h3F, 6'h00, 1, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
